// File: rtl/timer_pkg.sv
// timer_pkg: shared encodings for the interval timer controller.
//   state_t       : controller FSM states (2-bit: IDLE, LOAD, RUN)
//   MODE_ONESHOT  : stop after the first terminal count
//   MODE_PERIODIC : keep running, reload on every terminal count
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/timer_stage.sv
// timer_stage: one stage of the cascaded counter.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   clr  : synchronous clear, wins over ce
//   ce   : count enable
//   term : terminal value; the stage wraps to 0 after reaching it
//   q    : current count
//   ov   : terminal pulse (ce while q==term), drives the next stage's ce
module timer_stage #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         ce,
    input  logic [N-1:0] term,
    output logic [N-1:0] q,
    output logic         ov
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    // Equality against the terminal value is the only wrap source; since
    // term fits in N bits, q never runs past it.
    assign ov = ce && (q == term);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (ov) begin
            q <= '0;
        end else if (ce) begin
            q <= q + ONE;
        end
    end

endmodule

// File: rtl/interval_timer_ctrl.sv
// interval_timer_ctrl: sequences a prescaler stage feeding a main period
// stage, turning start/stop command pulses into counter enables.
//   clk, rst   : clock (rising edge) and asynchronous active-low reset
//   start      : one-cycle command, arm and run (honoured only in IDLE)
//   stop       : one-cycle command, abort (honoured in LOAD and RUN)
//   mode       : 0 one-shot, 1 periodic; latched in LOAD
//   prescale   : prescaler terminal value; latched in LOAD
//   period     : main terminal value; latched in LOAD
//   irq_clr    : clears the sticky interrupt
//   busy       : high in LOAD and RUN
//   tick       : prescaler terminal pulse (main counter enable)
//   count      : main counter value
//   done       : one-cycle terminal-count pulse
//   irq        : sticky interrupt, set by done
//   dbg_state  : current FSM state
//   dbg_pre    : current prescaler value
// Command semantics: start and stop are sampled on every rising edge with
// no back-pressure; a command is accepted only in a state that reacts to
// it and is otherwise dropped. stop always wins over start and over a
// coincident terminal tick.
module interval_timer_ctrl
    import timer_pkg::*;
#(
    parameter int PW = 4,
    parameter int CW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic          mode,
    input  logic [PW-1:0] prescale,
    input  logic [CW-1:0] period,
    input  logic          irq_clr,
    output logic          busy,
    output logic          tick,
    output logic [CW-1:0] count,
    output logic          done,
    output logic          irq,
    output logic [1:0]    dbg_state,
    output logic [PW-1:0] dbg_pre
);

    state_t        state, state_nxt;
    logic          mode_q;
    logic [PW-1:0] prescale_q;
    logic [CW-1:0] period_q;
    logic          run;
    logic          cnt_clr;
    logic          main_ov;

    assign run     = (state == ST_RUN);
    // Counters sit at 0 outside RUN, and a stop in RUN clears them on the
    // same edge that returns the FSM to IDLE.
    assign cnt_clr = !run || stop;

    timer_stage #(.N(PW)) u_pre (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .ce   (run),
        .term (prescale_q),
        .q    (dbg_pre),
        .ov   (tick)
    );

    timer_stage #(.N(CW)) u_main (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .ce   (tick),
        .term (period_q),
        .q    (count),
        .ov   (main_ov)
    );

    // A stop arriving on the terminal tick suppresses done (and thus irq).
    assign done      = main_ov && !stop;
    assign busy      = (state == ST_LOAD) || (state == ST_RUN);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start && !stop) state_nxt = ST_LOAD;
            ST_LOAD: state_nxt = stop ? ST_IDLE : ST_RUN;
            ST_RUN: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                end else if (done && (mode_q == MODE_ONESHOT)) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Configuration is captured once per run; inputs are ignored in RUN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q     <= MODE_ONESHOT;
            prescale_q <= '0;
            period_q   <= '0;
        end else if (state == ST_LOAD) begin
            mode_q     <= mode;
            prescale_q <= prescale;
            period_q   <= period;
        end
    end

    // Set has priority over clear so a terminal count is never lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq <= 1'b0;
        end else if (done) begin
            irq <= 1'b1;
        end else if (irq_clr) begin
            irq <= 1'b0;
        end
    end

endmodule

// File: doc/interval_timer_ctrl.md
Name: interval_timer_ctrl

Overview:
Controller that sequences a two-stage cascaded counter: a prescaler stage feeding a main period stage. It turns software-style start/stop commands into counter enables. It supports one-shot and periodic modes and raises a done pulse plus a sticky interrupt at terminal count. It sits between a register interface or top-level control logic and the timebase counters used across the FPGA experiments.

Parameters:
PW, 4, prescaler width in bits; prescale range 0..2^PW-1
CW, 10, main counter width in bits; period range 0..2^CW-1

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
start  in  1  single-cycle command: arm and run
stop  in  1  single-cycle command: abort
mode  in  1  0 = one-shot, 1 = periodic; sampled in LOAD
prescale  in  PW  prescaler terminal value; sampled in LOAD
period  in  CW  main terminal value; sampled in LOAD
irq_clr  in  1  clears irq
busy  out  1  high in LOAD and RUN
tick  out  1  prescaler terminal pulse (main counter enable)
count  out  CW  main counter value
done  out  1  single-cycle terminal pulse
irq  out  1  sticky interrupt flag

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; prescaler=0; count=0; latched mode/prescale/period=0; irq=0. busy, tick and done are 0.
- FSM states are IDLE, LOAD and RUN.
  - IDLE: start=1 and stop=0 -> LOAD. Otherwise stay in IDLE. Counters are held at 0.
  - LOAD: one cycle. Latch mode, prescale and period. Clear both counters. Go to RUN; stop=1 here -> IDLE instead.
  - RUN: stop=1 -> IDLE, counters cleared, no done pulse. start is ignored.
- Prescaler: in RUN, increments every cycle. tick = (state==RUN) && (pre_cnt==prescale_q), combinational. On tick the prescaler wraps to 0. With prescale_q=0, tick is high on every RUN cycle.
- Main counter: increments only on tick. done = tick && (count==period_q) && !stop, combinational. On done, count wraps to 0.
  - Periodic mode: stay in RUN.
  - One-shot mode: go to IDLE on the next edge.
  - With period_q=0, done fires on every tick.
- Timing:
  - start sampled in cycle 0 -> LOAD in cycle 1 -> first RUN cycle is cycle 2.
  - First done occurs in cycle 2+(period+1)*(prescale+1)-1.
  - In periodic mode, done pulses are spaced exactly (period+1)*(prescale+1) cycles apart.
- Changing inputs during RUN has no effect. Only the LOAD-latched values are used.
- irq: set on done, cleared by irq_clr. When both occur in the same cycle, set wins. irq is independent of state and survives stop.
- Simultaneous events:
  - stop together with a terminal tick: stop wins; no done, no irq.
  - start together with stop in IDLE: stay in IDLE.
- busy=1 exactly in LOAD and RUN. A one-shot run drops busy on the cycle after done.
- Arithmetic:
  - Counters are unsigned, fixed width, with no saturation.
  - Equality compare against the latched terminal value is the only wrap source.
  - The counter can never pass its terminal value, because the terminal value is latched and fits the counter width.

Decomposition:
- Package timer_pkg:
  - state encoding constants ST_IDLE, ST_LOAD, ST_RUN (2-bit)
  - mode constants MODE_ONESHOT=0, MODE_PERIODIC=1
- Sub-module timer_stage, instantiated twice (widths PW and CW):
  - parameter N
  - ports clk, rst, clr, ce, term[N-1:0], q[N-1:0], ov
  - ov = ce && (q==term); wraps to 0 on ov; clr takes priority over ce.
- The main stage's ce is the prescaler stage's ov, i.e. a cascade.
- The FSM, the latches and irq live in interval_timer_ctrl.

Test Plan:
- Reset mid-RUN: start with prescale=3, period=5, assert rst low at cycle 10 -> busy, count, tick, done and irq all 0 immediately (asynchronously); FSM in IDLE after release.
- One-shot: mode=0, prescale=1, period=2, start at cycle 0 -> ticks in cycles 3, 5, 7; done and irq in cycle 7; busy low from cycle 8; count back to 0.
- Periodic: mode=1, prescale=0, period=3 -> done in cycles 5, 9, 13, …; count sequence 0,1,2,3,0.
- Stop collides with terminal tick: periodic, prescale=0, period=1, stop in cycle 3 (the done cycle) -> done=0, irq stays 0, IDLE in cycle 4.
- Inputs changed during RUN: change period from 2 to 7 in cycle 4 of a one-shot run with prescale=0 -> done still in cycle 4, using the latched value 2.
- irq set/clear collision: irq_clr held high across a done cycle -> irq=1 after that edge; irq_clr on the next cycle -> irq=0.
